// File: rtl/bridge_bus_arbiter.sv
// -----------------------------------------------------------------------------
// bridge_bus_arbiter
//
// Two-master arbiter for the system bridge bus (DM, TC1, TC2, interrupt window).
// M0 is the CPU data port, M1 a second bus master (DMA or debug). One single-beat
// transaction is granted at a time. The winner's address, write data and byte
// enables are registered onto the shared slave-side bus. Read data, ack and
// error go back to the owning master only. The bridge decode sits downstream.
//
// Parameters
//   FAIR            1 = round-robin on ties, 0 = fixed priority (M0 always wins)
//   TIMEOUT_CYCLES  stall cycles before a forced abort (>= 1, BUS_TIMEOUT_EN only)
//
// Optional feature macro
//   BUS_TIMEOUT_EN  when defined, a stalled slave access is aborted with err=1
//                   after TIMEOUT_CYCLES cycles without s_ready; when undefined,
//                   BUSY waits for s_ready indefinitely
//
// Ports
//   clk                  clock, rising edge
//   reset                asynchronous, active-low reset
//   m0_req / m1_req      master request, held high until the matching ack
//   m0_addr / m1_addr    32-bit byte address
//   m0_wdata / m1_wdata  32-bit write data
//   m0_byteen / m1_byteen 4-bit byte enables, 0000 = read
//   m0_ack / m1_ack      one-cycle completion pulse
//   m0_rdata / m1_rdata  read data, valid while ack=1
//   m0_err / m1_err      error flag, valid while ack=1
//   s_req                slave request, high for the whole transaction
//   s_addr/s_wdata/s_byteen  registered request of the owner
//   s_ready              slave completes in a cycle with s_req=1 and s_ready=1
//   s_rdata / s_err      slave response, sampled when s_ready=1
//   busy                 high while a transaction is in flight or responding
//   owner                current or last granted master
// -----------------------------------------------------------------------------
module bridge_bus_arbiter #(
   parameter int FAIR           = 1,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_req,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_byteen,
   output logic        m0_ack,
   output logic [31:0] m0_rdata,
   output logic        m0_err,
   input  logic        m1_req,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_byteen,
   output logic        m1_ack,
   output logic [31:0] m1_rdata,
   output logic        m1_err,
   output logic        s_req,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   output logic [3:0]  s_byteen,
   input  logic        s_ready,
   input  logic [31:0] s_rdata,
   input  logic        s_err,
   output logic        busy,
   output logic        owner
);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("bridge_bus_arbiter: TIMEOUT_CYCLES must be >= 1");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state_q;
   state_t state_d;

   logic last_owner_q;
   logic any_req;
   logic grant_sel;
   logic grant_en;
   logic done_en;
   logic timeout_hit;

   assign any_req = m0_req | m1_req;

   // Winner of an IDLE arbitration. last_owner_q resets to 1 so M0 takes the
   // first tie in round-robin mode.
   always_comb begin
      grant_sel = 1'b0;
      if (m0_req && m1_req) begin
         grant_sel = (FAIR != 0) ? ~last_owner_q : 1'b0;
      end else begin
         grant_sel = m1_req;
      end
   end

`ifdef BUS_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   // Counts completed stall cycles of the current transaction. The abort fires
   // in the stall cycle that brings the count to TIMEOUT_CYCLES; a slave that
   // answers in that same cycle still completes normally.
   logic [CNT_W-1:0] stall_cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_q <= '0;
      end else if (grant_en) begin
         stall_cnt_q <= '0;
      end else if (state_q == BUSY && !s_ready) begin
         stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
   end

   assign timeout_hit = (state_q == BUSY) && !s_ready && (stall_cnt_q == STALL_LAST);
`else
   assign timeout_hit = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_req) state_d = BUSY;
         BUSY:    if (s_ready || timeout_hit) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs and datapath strobes
   always_comb begin
      busy     = (state_q == BUSY) || (state_q == RESP);
      grant_en = (state_q == IDLE) && any_req;
      done_en  = (state_q == BUSY) && (s_ready || timeout_hit);
   end

   // Registered slave bus and master responses. The response registers are
   // cleared in every cycle that does not complete a transaction, which is
   // what makes ack a single-cycle pulse in RESP.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s_req        <= 1'b0;
         s_addr       <= '0;
         s_wdata      <= '0;
         s_byteen     <= '0;
         owner        <= 1'b0;
         last_owner_q <= 1'b1;
         m0_ack       <= 1'b0;
         m0_rdata     <= '0;
         m0_err       <= 1'b0;
         m1_ack       <= 1'b0;
         m1_rdata     <= '0;
         m1_err       <= 1'b0;
      end else begin
         m0_ack   <= 1'b0;
         m0_rdata <= '0;
         m0_err   <= 1'b0;
         m1_ack   <= 1'b0;
         m1_rdata <= '0;
         m1_err   <= 1'b0;
         if (grant_en) begin
            s_req    <= 1'b1;
            owner    <= grant_sel;
            s_addr   <= grant_sel ? m1_addr   : m0_addr;
            s_wdata  <= grant_sel ? m1_wdata  : m0_wdata;
            s_byteen <= grant_sel ? m1_byteen : m0_byteen;
         end else if (done_en) begin
            s_req        <= 1'b0;
            s_addr       <= '0;
            s_wdata      <= '0;
            s_byteen     <= '0;
            last_owner_q <= owner;
            // A timeout completion returns err=1 with zero read data.
            if (owner) begin
               m1_ack   <= 1'b1;
               m1_rdata <= s_ready ? s_rdata : '0;
               m1_err   <= s_ready ? s_err : 1'b1;
            end else begin
               m0_ack   <= 1'b1;
               m0_rdata <= s_ready ? s_rdata : '0;
               m0_err   <= s_ready ? s_err : 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_bridge_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bridge_bus_arbiter
//
// Directed bench for bridge_bus_arbiter. Two instances share every input: one
// round-robin (FAIR=1) and one fixed-priority (FAIR=0). Both run with
// TIMEOUT_CYCLES=4 so the timeout scenario is exercised when BUS_TIMEOUT_EN is
// defined. Inputs change 1 time unit after the rising edge; outputs are
// checked at that same point, i.e. away from the active edge.
// -----------------------------------------------------------------------------
module tb_bridge_bus_arbiter;

   localparam int TO = 4;

   logic        clk;
   logic        reset;
   logic        m0_req, m1_req, s_ready, s_err;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, s_rdata;
   logic [3:0]  m0_byteen, m1_byteen;

   logic        m0_ack, m0_err, m1_ack, m1_err, s_req, busy, owner;
   logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
   logic [3:0]  s_byteen;

   logic        b_m0_ack, b_m0_err, b_m1_ack, b_m1_err, b_s_req, b_busy, b_owner;
   logic [31:0] b_m0_rdata, b_m1_rdata, b_s_addr, b_s_wdata;
   logic [3:0]  b_s_byteen;

   int total;
   int bad;

   bridge_bus_arbiter #(.FAIR(1), .TIMEOUT_CYCLES(TO)) dut_rr (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_byteen(m0_byteen),
      .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_byteen(m1_byteen),
      .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
      .s_req(s_req), .s_addr(s_addr), .s_wdata(s_wdata), .s_byteen(s_byteen),
      .s_ready(s_ready), .s_rdata(s_rdata), .s_err(s_err),
      .busy(busy), .owner(owner)
   );

   bridge_bus_arbiter #(.FAIR(0), .TIMEOUT_CYCLES(TO)) dut_fp (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_byteen(m0_byteen),
      .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata), .m0_err(b_m0_err),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_byteen(m1_byteen),
      .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata), .m1_err(b_m1_err),
      .s_req(b_s_req), .s_addr(b_s_addr), .s_wdata(b_s_wdata), .s_byteen(b_s_byteen),
      .s_ready(s_ready), .s_rdata(s_rdata), .s_err(s_err),
      .busy(b_busy), .owner(b_owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      tick;
      tick;
      total++;
      if ({s_req, busy, owner, m0_ack, m1_ack, m0_err, m1_err} !== 7'b0) begin
         bad++;
         $display("FAIL reset_ctrl: got %b want 0000000", {s_req, busy, owner, m0_ack, m1_ack, m0_err, m1_err});
      end
      total++;
      if ({m0_rdata, m1_rdata, s_addr, s_wdata, s_byteen} !== 132'b0) begin
         bad++;
         $display("FAIL reset_data: got %h want 0", {m0_rdata, m1_rdata, s_addr, s_wdata, s_byteen});
      end
      // Start an M0 access, then pull reset in the middle of BUSY.
      reset = 1'b1;
      m0_req = 1'b1; m0_addr = 32'h0000_1000;
      tick;
      total++;
      if ({s_req, busy} !== 2'b11) begin
         bad++;
         $display("FAIL reset_pre_busy: got %b want 11", {s_req, busy});
      end
      #2 reset = 1'b0;
      #1;
      total++;
      if ({s_req, busy, m0_ack, m1_ack} !== 4'b0) begin
         bad++;
         $display("FAIL reset_async: got %b want 0000", {s_req, busy, m0_ack, m1_ack});
      end
      m0_req = 1'b0;
      tick;
      reset = 1'b1;
      m1_req = 1'b1; m1_addr = 32'h0000_2000;
      tick;
      total++;
      if ({s_req, owner, s_addr} !== {1'b1, 1'b1, 32'h0000_2000}) begin
         bad++;
         $display("FAIL reset_m1_grant: got %b %b %h want 1 1 00002000", s_req, owner, s_addr);
      end
      s_ready = 1'b1; s_rdata = 32'h0000_00A5;
      tick;
      total++;
      if ({m1_ack, m1_rdata, m0_ack} !== {1'b1, 32'h0000_00A5, 1'b0}) begin
         bad++;
         $display("FAIL reset_m1_ack: got %b %h %b want 1 000000a5 0", m1_ack, m1_rdata, m0_ack);
      end
      m1_req = 1'b0; s_ready = 1'b0;
      tick;
      total++;
      if ({m1_ack, busy} !== 2'b00) begin
         bad++;
         $display("FAIL reset_m1_done: got %b want 00", {m1_ack, busy});
      end
   endtask

   task automatic test_tie_fair;
      logic exp;
      m0_req = 1'b1; m0_addr = 32'h0000_A000;
      m1_req = 1'b1; m1_addr = 32'h0000_B000;
      for (int i = 0; i < 4; i++) begin
         exp = i[0];
         tick;
         total++;
         if ({s_req, owner, s_addr} !== {1'b1, exp, (exp ? 32'h0000_B000 : 32'h0000_A000)}) begin
            bad++;
            $display("FAIL tie_grant[%0d]: got %b %b %h want owner %b", i, s_req, owner, s_addr, exp);
         end
         total++;
         if (b_owner !== 1'b0) begin
            bad++;
            $display("FAIL tie_fixed_owner[%0d]: got %b want 0", i, b_owner);
         end
         s_ready = 1'b1; s_rdata = 32'h0000_0100 + 32'(i);
         tick;
         total++;
         if ({m0_ack, m1_ack, (exp ? m1_rdata : m0_rdata), (exp ? m0_rdata : m1_rdata)}
             !== {~exp, exp, 32'h0000_0100 + 32'(i), 32'h0}) begin
            bad++;
            $display("FAIL tie_ack[%0d]: got acks %b%b rdata %h/%h want owner %b", i, m0_ack, m1_ack, m0_rdata, m1_rdata, exp);
         end
         total++;
         if ({b_m0_ack, b_m1_ack} !== 2'b10) begin
            bad++;
            $display("FAIL tie_fixed_ack[%0d]: got %b want 10", i, {b_m0_ack, b_m1_ack});
         end
         s_ready = 1'b0;
         tick;
      end
      m0_req = 1'b0; m1_req = 1'b0;
      tick;
   endtask

   task automatic test_fixed;
      m0_req = 1'b1; m0_addr = 32'h0000_C000;
      m1_req = 1'b1; m1_addr = 32'h0000_D000;
      for (int i = 0; i < 2; i++) begin
         tick;
         total++;
         if ({b_s_req, b_owner, b_s_addr} !== {1'b1, 1'b0, 32'h0000_C000}) begin
            bad++;
            $display("FAIL fixed_grant[%0d]: got %b %b %h want 1 0 0000c000", i, b_s_req, b_owner, b_s_addr);
         end
         s_ready = 1'b1; s_rdata = 32'h0000_0200;
         tick;
         total++;
         if ({b_m0_ack, b_m1_ack} !== 2'b10) begin
            bad++;
            $display("FAIL fixed_ack[%0d]: got %b want 10", i, {b_m0_ack, b_m1_ack});
         end
         s_ready = 1'b0;
         if (i == 1) m0_req = 1'b0;
         tick;
      end
      tick;
      total++;
      if ({b_s_req, b_owner, b_s_addr} !== {1'b1, 1'b1, 32'h0000_D000}) begin
         bad++;
         $display("FAIL fixed_m1_grant: got %b %b %h want 1 1 0000d000", b_s_req, b_owner, b_s_addr);
      end
      s_ready = 1'b1; s_rdata = 32'h0000_0077;
      tick;
      total++;
      if ({b_m0_ack, b_m1_ack, b_m1_rdata} !== {2'b01, 32'h0000_0077}) begin
         bad++;
         $display("FAIL fixed_m1_ack: got %b %h want 01 00000077", {b_m0_ack, b_m1_ack}, b_m1_rdata);
      end
      m1_req = 1'b0; s_ready = 1'b0;
      tick;
   endtask

   task automatic test_single_read;
      m0_req = 1'b1; m0_addr = 32'h0000_7F00; m0_byteen = 4'b0000;
      tick;
      total++;
      if ({s_req, owner, s_addr, s_byteen} !== {1'b1, 1'b0, 32'h0000_7F00, 4'b0000}) begin
         bad++;
         $display("FAIL read_grant: got %b %b %h %b want 1 0 00007f00 0000", s_req, owner, s_addr, s_byteen);
      end
      s_ready = 1'b1; s_rdata = 32'h0000_1234;
      tick;
      total++;
      if ({m0_ack, m0_rdata, m0_err, m1_ack, s_req, s_addr} !== {1'b1, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 32'h0}) begin
         bad++;
         $display("FAIL read_ack: got ack %b rdata %h err %b m1_ack %b s_req %b s_addr %h", m0_ack, m0_rdata, m0_err, m1_ack, s_req, s_addr);
      end
      m0_req = 1'b0; s_ready = 1'b0;
      tick;
      total++;
      if ({m0_ack, m0_rdata, busy} !== 34'b0) begin
         bad++;
         $display("FAIL read_clear: got %b %h %b want 0 0 0", m0_ack, m0_rdata, busy);
      end
   endtask

   task automatic test_slave_error;
      m0_req = 1'b1; m0_addr = 32'h0000_9000; m0_wdata = 32'hCAFE_F00D; m0_byteen = 4'b1111;
      tick;
      total++;
      if ({s_req, s_addr, s_wdata, s_byteen} !== {1'b1, 32'h0000_9000, 32'hCAFE_F00D, 4'b1111}) begin
         bad++;
         $display("FAIL err_write_bus: got %b %h %h %b", s_req, s_addr, s_wdata, s_byteen);
      end
      s_ready = 1'b1; s_err = 1'b1; s_rdata = 32'h0;
      tick;
      total++;
      if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b1100) begin
         bad++;
         $display("FAIL err_ack: got %b want 1100", {m0_ack, m0_err, m1_ack, m1_err});
      end
      m0_req = 1'b0; s_ready = 1'b0; s_err = 1'b0;
      tick;
      total++;
      if ({m0_ack, m0_err, busy, s_addr, s_wdata, s_byteen} !== 71'b0) begin
         bad++;
         $display("FAIL err_clear: got %b%b%b %h %h %b", m0_ack, m0_err, busy, s_addr, s_wdata, s_byteen);
      end
   endtask

   task automatic test_protocol_edges;
      // s_ready with no transaction in flight is ignored.
      s_ready = 1'b1; s_rdata = 32'h0000_0999;
      tick;
      tick;
      total++;
      if ({busy, s_req, m0_ack, m1_ack} !== 4'b0) begin
         bad++;
         $display("FAIL idle_ready: got %b want 0000", {busy, s_req, m0_ack, m1_ack});
      end
      s_ready = 1'b0;
      // M1 withdraws its request right after the grant: access still completes.
      m1_req = 1'b1; m1_addr = 32'h0000_E000; m1_wdata = 32'h0000_0055; m1_byteen = 4'b0011;
      tick;
      m1_req = 1'b0;
      tick;
      total++;
      if ({s_req, busy, s_addr, s_byteen} !== {2'b11, 32'h0000_E000, 4'b0011}) begin
         bad++;
         $display("FAIL withdraw_hold: got %b%b %h %b", s_req, busy, s_addr, s_byteen);
      end
      s_ready = 1'b1; s_rdata = 32'h0000_0099;
      tick;
      total++;
      if ({m1_ack, m1_rdata, m0_ack} !== {1'b1, 32'h0000_0099, 1'b0}) begin
         bad++;
         $display("FAIL withdraw_ack: got %b %h %b want 1 00000099 0", m1_ack, m1_rdata, m0_ack);
      end
      // A request raised during RESP waits until IDLE.
      s_ready = 1'b0; m0_req = 1'b1; m0_addr = 32'h0000_3300;
      tick;
      total++;
      if ({s_req, busy, m1_ack} !== 3'b000) begin
         bad++;
         $display("FAIL resp_req_ignored: got %b want 000", {s_req, busy, m1_ack});
      end
      tick;
      total++;
      if ({s_req, owner, s_addr} !== {2'b10, 32'h0000_3300}) begin
         bad++;
         $display("FAIL resp_req_granted: got %b %b %h want 1 0 00003300", s_req, owner, s_addr);
      end
      s_ready = 1'b1;
      tick;
      m0_req = 1'b0; s_ready = 1'b0;
      tick;
   endtask

`ifdef BUS_TIMEOUT_EN
   task automatic test_timeout;
      m0_req = 1'b1; m0_addr = 32'h0000_F000; m0_byteen = 4'b0000;
      s_rdata = 32'hDEAD_BEEF; s_ready = 1'b0;
      tick;
      for (int c = 2; c <= 4; c++) begin
         tick;
         total++;
         if ({m0_ack, s_req} !== 2'b01) begin
            bad++;
            $display("FAIL timeout_wait[%0d]: got %b want 01", c, {m0_ack, s_req});
         end
      end
      tick;
      total++;
      if ({m0_ack, m0_err, m0_rdata, s_req} !== {2'b11, 32'h0, 1'b0}) begin
         bad++;
         $display("FAIL timeout_abort: got ack %b err %b rdata %h s_req %b", m0_ack, m0_err, m0_rdata, s_req);
      end
      m0_req = 1'b0;
      tick;
      m0_req = 1'b1;
      tick;
      tick;
      tick;
      tick;
      s_ready = 1'b1;
      tick;
      total++;
      if ({m0_ack, m0_err, m0_rdata} !== {2'b10, 32'hDEAD_BEEF}) begin
         bad++;
         $display("FAIL timeout_race: got ack %b err %b rdata %h want 1 0 deadbeef", m0_ack, m0_err, m0_rdata);
      end
      m0_req = 1'b0; s_ready = 1'b0;
      tick;
   endtask
`endif

   initial begin
      total = 0; bad = 0;
      reset = 1'b0;
      m0_req = 1'b0; m0_addr = '0; m0_wdata = '0; m0_byteen = '0;
      m1_req = 1'b0; m1_addr = '0; m1_wdata = '0; m1_byteen = '0;
      s_ready = 1'b0; s_rdata = '0; s_err = 1'b0;
      test_reset;
      test_tie_fair;
      test_fixed;
      test_single_read;
      test_slave_error;
      test_protocol_edges;
`ifdef BUS_TIMEOUT_EN
      test_timeout;
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: run did not complete within time limit");
      $fatal(1);
   end

endmodule
